sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 109 ++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Multi-cycle bridge from a 32-bit MEM-stage load/store port to a 16-bit asynchronous SRAM.
// Each access moves two half-words and holds READY low for WAIT_CYCLES cycles.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RD_EN,
  input  logic        WR_EN,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        READY,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  // Length of the WAIT state; clamped to 1 so the counter stays legal when WAIT is skipped.
  localparam int unsigned WaitLen = (WAIT_CYCLES > 3) ? WAIT_CYCLES - 3 : 1;
  localparam int unsigned CntW    = $clog2(WaitLen + 1);

  typedef enum logic [2:0] {StIdle, StAccLo, StAccHi, StWait, StDone} state_e;

  state_e            state_q;
  logic [16:0]       index_q;
  logic [31:0]       data_q;
  logic              is_write_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       read_data_q;

  logic [16:0]       index_in;
  logic              req;
  logic              wr_phase;
  logic              hi_half;

  assign req      = RD_EN | WR_EN;
  assign index_in = 17'((ADDRESS - 32'(ADDR_BASE)) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      index_q     <= '0;
      data_q      <= '0;
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      read_data_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            index_q    <= index_in;
            data_q     <= WRITE_DATA;
            is_write_q <= WR_EN;
            state_q    <= StAccLo;
          end
        end
        StAccLo: begin
          if (!is_write_q) read_data_q[15:0] <= SRAM_DQ;
          state_q <= StAccHi;
        end
        StAccHi: begin
          if (!is_write_q) read_data_q[31:16] <= SRAM_DQ;
          if (WAIT_CYCLES > 3) begin
            cnt_q   <= CntW'(WaitLen);
            state_q <= StWait;
          end else begin
            state_q <= StDone;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) state_q <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // The bus is only driven while a write is actually strobing the SRAM.
  assign wr_phase = is_write_q && (state_q == StAccLo || state_q == StAccHi);
  assign hi_half  = (state_q == StAccHi) || (state_q == StWait) || (state_q == StDone);

  assign SRAM_WE_N = ~wr_phase;
  assign SRAM_DQ   = wr_phase ? ((state_q == StAccHi) ? data_q[31:16] : data_q[15:0]) : 16'hzzzz;
  assign SRAM_ADDR = {index_q, hi_half};
  assign READ_DATA = read_data_q;

  always_comb begin
    READY = 1'b0;
    unique case (state_q)
      StIdle:  READY = ~req;
      StDone:  READY = 1'b1;
      default: READY = 1'b0;
    endcase
  end

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule
